// File: rtl/div_sqrt_iter_mvp_if.sv
// rtl/div_sqrt_iter_mvp_if.sv - request/response bundle for the iterative divide/sqrt mantissa engine
interface div_sqrt_iter_mvp_if #(
  parameter int MANT_W = 53
);
  localparam int RES_W = MANT_W + 2;

  logic              in_valid;
  logic              in_ready;
  logic              op_sqrt;
  logic [1:0]        fmt;
  logic [5:0]        prec;
  logic              exp_odd;
  logic [MANT_W-1:0] mant_a;
  logic [MANT_W-1:0] mant_b;
  logic              kill;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  res;
  logic              sticky;

  modport master (
    output in_valid, op_sqrt, fmt, prec, exp_odd, mant_a, mant_b, kill, out_ready,
    input  in_ready, out_valid, res, sticky
  );

  modport slave (
    input  in_valid, op_sqrt, fmt, prec, exp_odd, mant_a, mant_b, kill, out_ready,
    output in_ready, out_valid, res, sticky
  );
endinterface

// File: rtl/div_sqrt_iter_mvp.sv
// rtl/div_sqrt_iter_mvp.sv - restoring radix-2 divide/sqrt mantissa engine, ITER_UNITS steps per cycle
module div_sqrt_iter_mvp #(
  parameter int ITER_UNITS = 2,
  parameter int MANT_W     = 53
) (
  input logic             clk,
  input logic             rst_n,
  div_sqrt_iter_mvp_if.slave bus
);
  localparam int RES_W = MANT_W + 2;
  // Remainder: MANT_W+2 fraction bits (enough for the 2^-N sqrt trial term) plus 4 integer bits.
  localparam int REM_W = MANT_W + 6;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state, state_nx;
  logic [REM_W-1:0] rem_q, rem_nx, dvs_q;
  logic [RES_W-1:0] res_q, res_nx, mask_q, mask_nx;
  logic [6:0]       cnt_q, cnt_nx, n_q, n_in, p_full, pe;
  logic             sqrt_q, sticky_q, sticky_nx, accept;

  logic [REM_W-1:0] r, d;
  logic [RES_W-1:0] q, m;
  logic [6:0]       c;

  always_comb begin
    case (bus.fmt)
      2'b00:   p_full = 7'd24;
      2'b01:   p_full = 7'd53;
      2'b10:   p_full = 7'd11;
      default: p_full = 7'd8;
    endcase
    pe   = (bus.prec == 6'd0 || {1'b0, bus.prec} > p_full) ? p_full : {1'b0, bus.prec};
    n_in = pe + 7'd2;
  end

  assign accept = (state == IDLE) && bus.in_valid && !bus.kill;

  // Sqrt subtrahend is 2Q + 2^-i; the one-hot mask marks weight 2^-i in result alignment.
  always_comb begin
    r = rem_q;
    q = res_q;
    m = mask_q;
    c = cnt_q;
    d = '0;
    for (int u = 0; u < ITER_UNITS; u++) begin
      if (c < n_q) begin
        d = sqrt_q ? ({2'b00, q, 2'b00} + {3'b000, m, 1'b0}) : dvs_q;
        if (r >= d) begin
          r = r - d;
          q = q | m;
        end
        r = r << 1;
        m = m >> 1;
        c = c + 7'd1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    rem_nx    = rem_q;
    res_nx    = res_q;
    mask_nx   = mask_q;
    cnt_nx    = cnt_q;
    sticky_nx = sticky_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx  = ITER;
          rem_nx    = (bus.op_sqrt && bus.exp_odd) ? {2'b00, bus.mant_a, 4'b0000}
                                                   : {3'b000, bus.mant_a, 3'b000};
          res_nx    = '0;
          mask_nx   = {1'b1, {(RES_W-1){1'b0}}};
          cnt_nx    = '0;
          sticky_nx = 1'b0;
        end
      end
      ITER: begin
        rem_nx  = r;
        res_nx  = q;
        mask_nx = m;
        cnt_nx  = c;
        if (c == n_q) begin
          state_nx  = DONE;
          sticky_nx = (r != '0);
        end
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (bus.kill) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rem_q    <= '0;
      res_q    <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      dvs_q    <= '0;
      n_q      <= '0;
      sqrt_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      rem_q    <= rem_nx;
      res_q    <= res_nx;
      mask_q   <= mask_nx;
      cnt_q    <= cnt_nx;
      sticky_q <= sticky_nx;
      if (accept) begin
        dvs_q  <= {3'b000, bus.mant_b, 3'b000};
        n_q    <= n_in;
        sqrt_q <= bus.op_sqrt;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.res       = res_q;
  assign bus.sticky    = sticky_q;
endmodule

// File: tb/tb_div_sqrt_iter_mvp.sv
// tb/tb_div_sqrt_iter_mvp.sv - directed bench for div_sqrt_iter_mvp with ITER_UNITS=2 and ITER_UNITS=3 instances
module tb_div_sqrt_iter_mvp;
  localparam logic [52:0] ONE  = 53'h10_0000_0000_0000;
  localparam logic [52:0] HALF3 = 53'h18_0000_0000_0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  div_sqrt_iter_mvp_if #(.MANT_W(53)) d2 ();
  div_sqrt_iter_mvp_if #(.MANT_W(53)) d3 ();

  div_sqrt_iter_mvp #(.ITER_UNITS(2), .MANT_W(53)) u2 (.clk(clk), .rst_n(rst_n), .bus(d2.slave));
  div_sqrt_iter_mvp #(.ITER_UNITS(3), .MANT_W(53)) u3 (.clk(clk), .rst_n(rst_n), .bus(d3.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_op(input logic op, input logic [1:0] fmt, input logic [5:0] prec,
                        input logic odd, input logic [52:0] a, input logic [52:0] b);
    d2.op_sqrt = op;  d3.op_sqrt = op;
    d2.fmt     = fmt; d3.fmt     = fmt;
    d2.prec    = prec; d3.prec   = prec;
    d2.exp_odd = odd; d3.exp_odd = odd;
    d2.mant_a  = a;   d3.mant_a  = a;
    d2.mant_b  = b;   d3.mant_b  = b;
  endtask

  task automatic start(input logic op, input logic [1:0] fmt, input logic [5:0] prec,
                       input logic odd, input logic [52:0] a, input logic [52:0] b);
    @(negedge clk);
    set_op(op, fmt, prec, odd, a, b);
    d2.in_valid = 1'b1; d3.in_valid = 1'b1;
    @(negedge clk);
    d2.in_valid = 1'b0; d3.in_valid = 1'b0;
    // scramble operands after the accept edge; the engine must have latched them
    set_op(~op, ~fmt, 6'($urandom), ~odd, 53'($urandom), 53'($urandom));
  endtask

  task automatic wait_both(output int l2, output int l3);
    l2 = -1;
    l3 = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (l2 < 0 && d2.out_valid) l2 = c;
      if (l3 < 0 && d3.out_valid) l3 = c;
      if (l2 >= 0 && l3 >= 0) break;
    end
  endtask

  task automatic run(input string tag, input logic op, input logic [1:0] fmt, input logic [5:0] prec,
                     input logic odd, input logic [52:0] a, input logic [52:0] b,
                     input logic [54:0] er, input logic es, input int el2, input int el3);
    int l2, l3;
    start(op, fmt, prec, odd, a, b);
    wait_both(l2, l3);
    check({tag, "_lat2"}, 64'(l2), 64'(el2));
    check({tag, "_lat3"}, 64'(l3), 64'(el3));
    check({tag, "_res2"}, 64'(d2.res), 64'(er));
    check({tag, "_res3"}, 64'(d3.res), 64'(er));
    check({tag, "_sticky2"}, 64'(d2.sticky), 64'(es));
    check({tag, "_sticky3"}, 64'(d3.sticky), 64'(es));
  endtask

  task automatic finish_both(input string tag);
    @(negedge clk);
    d2.out_ready = 1'b1; d3.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_in_ready2"}, 64'(d2.in_ready), 64'd1);
    check({tag, "_out_valid2"}, 64'(d2.out_valid), 64'd0);
    check({tag, "_in_ready3"}, 64'(d3.in_ready), 64'd1);
    @(negedge clk);
    d2.out_ready = 1'b0; d3.out_ready = 1'b0;
  endtask

  task automatic no_output(input string tag);
    int seen;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (d2.out_valid || d3.out_valid || !d2.in_ready || !d3.in_ready) seen++;
    end
    check({tag, "_quiet"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [54:0] alt26, alt10, alt55, sqrt2, r0;
    logic        s0;
    int          bad;

    clk = 1'b0; rst_n = 1'b0; checks = 0; errors = 0;
    d2.in_valid = 1'b0; d3.in_valid = 1'b0;
    d2.kill = 1'b0;     d3.kill = 1'b0;
    d2.out_ready = 1'b0; d3.out_ready = 1'b0;
    set_op(1'b0, 2'b00, 6'd0, 1'b0, ONE, ONE);

    // 2/3 = 0.1010... : odd result bits set down to bit RES_W-N
    alt26 = '0; alt10 = '0; alt55 = '0;
    for (int i = 29; i <= 53; i += 2) alt26[i] = 1'b1;
    for (int i = 45; i <= 53; i += 2) alt10[i] = 1'b1;
    for (int i = 1; i <= 53; i += 2) alt55[i] = 1'b1;
    sqrt2 = {13'b1011010100000, 42'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(d2.in_ready), 64'd1);
    check("rst_out_valid", 64'(d2.out_valid), 64'd0);
    check("rst_res", 64'(d2.res), 64'd0);
    check("rst_sticky", 64'(d2.sticky), 64'd0);

    run("fp32_1p5_div_1", 1'b0, 2'b00, 6'd0, 1'b0, HALF3, ONE, 55'h60_0000_0000_0000, 1'b0, 13, 9);
    finish_both("hs1");
    run("fp32_1_div_1p5", 1'b0, 2'b00, 6'd0, 1'b0, ONE, HALF3, alt26, 1'b1, 13, 9);
    finish_both("hs2");
    run("fp16_sqrt2", 1'b1, 2'b10, 6'd0, 1'b1, ONE, HALF3, sqrt2, 1'b1, 7, 5);
    finish_both("hs3");
    run("fp16_sqrt1", 1'b1, 2'b10, 6'd0, 1'b0, ONE, HALF3, 55'h40_0000_0000_0000, 1'b0, 7, 5);
    finish_both("hs4");
    run("fp64_prec8", 1'b0, 2'b01, 6'd8, 1'b0, ONE, HALF3, alt10, 1'b1, 5, 4);
    finish_both("hs5");
    run("fp64_full", 1'b0, 2'b01, 6'd0, 1'b0, ONE, HALF3, alt55, 1'b1, 28, 19);
    finish_both("hs6");
    run("fp16alt_prec40", 1'b0, 2'b11, 6'd40, 1'b0, HALF3, ONE, 55'h60_0000_0000_0000, 1'b0, 5, 4);

    // backpressure: DONE must hold for 20 cycles with out_ready low
    r0 = d2.res;
    s0 = d2.sticky;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!d2.out_valid || d2.in_ready || d2.res !== r0 || d2.sticky !== s0) bad++;
    end
    check("bp_stable", 64'(bad), 64'd0);
    finish_both("bp_release");

    // kill sampled on ITER cycle 5
    start(1'b0, 2'b00, 6'd0, 1'b0, HALF3, ONE);
    repeat (4) @(negedge clk);
    d2.kill = 1'b1; d3.kill = 1'b1;
    @(posedge clk); #1;
    check("kill_iter_in_ready", 64'(d2.in_ready), 64'd1);
    check("kill_iter_in_ready3", 64'(d3.in_ready), 64'd1);
    @(negedge clk);
    d2.kill = 1'b0; d3.kill = 1'b0;
    no_output("kill_iter");
    run("after_kill", 1'b0, 2'b00, 6'd0, 1'b0, HALF3, ONE, 55'h60_0000_0000_0000, 1'b0, 13, 9);
    finish_both("hs_kill");

    // kill together with a request in IDLE: no accept
    @(negedge clk);
    set_op(1'b0, 2'b00, 6'd0, 1'b0, HALF3, ONE);
    d2.in_valid = 1'b1; d3.in_valid = 1'b1;
    d2.kill = 1'b1;     d3.kill = 1'b1;
    @(posedge clk); #1;
    check("kill_idle_in_ready", 64'(d2.in_ready), 64'd1);
    @(negedge clk);
    d2.in_valid = 1'b0; d3.in_valid = 1'b0;
    d2.kill = 1'b0;     d3.kill = 1'b0;
    no_output("kill_idle");
    run("after_kill_idle", 1'b0, 2'b00, 6'd0, 1'b0, HALF3, ONE, 55'h60_0000_0000_0000, 1'b0, 13, 9);
    finish_both("hs_kill_idle");

    // reset mid-ITER
    start(1'b0, 2'b00, 6'd0, 1'b0, ONE, HALF3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_in_ready", 64'(d2.in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(d2.out_valid), 64'd0);
    check("mid_rst_res", 64'(d2.res), 64'd0);
    check("mid_rst_sticky", 64'(d3.sticky), 64'd0);
    no_output("mid_rst");
    run("after_rst", 1'b0, 2'b00, 6'd0, 1'b0, HALF3, ONE, 55'h60_0000_0000_0000, 1'b0, 13, 9);
    finish_both("hs_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_sqrt_iter_mvp.md
# div_sqrt_iter_mvp

Multi-format iterative mantissa engine for floating-point divide and square root in the SFU float-divide path. It takes pre-unpacked, left-aligned mantissas (hidden bit included) and produces a truncated quotient or root plus a sticky bit. Special-case handling, exponent arithmetic and rounding happen in the neighbouring stages. It generalises the fixed 2-unit iteration of the previous generation: iteration units per cycle, mantissa width and per-operation precision control are all parameters or inputs.

## Interface
- ITER_UNITS, 2, radix-2 recurrence steps executed per cycle; legal 1..4
- MANT_W, 53, input mantissa width (C_MANT_FP64+1); the hidden bit sits at bit MANT_W-1 for every format
- RES_W, MANT_W+2, result width (derived; do not override)

- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid_i  in  1  operation request
- in_ready_o  out  1  engine idle, can accept
- op_sqrt_i  in  1  0 = divide A/B, 1 = square root of A
- fmt_i  in  2  00 FP32 (P=24), 01 FP64 (P=53), 10 FP16 (P=11), 11 FP16alt (P=8)
- prec_i  in  6  precision control; 0 = full P, else Pe=min(prec_i,P)
- exp_odd_i  in  1  sqrt only: radicand is 2·A instead of A
- mant_a_i  in  MANT_W  dividend/radicand, value in [1,2), bit MANT_W-1 = 1
- mant_b_i  in  MANT_W  divisor, value in [1,2); ignored for sqrt
- kill_i  in  1  abort current operation
- out_valid_o  out  1  result available
- out_ready_i  in  1  consumer accepts result
- res_o  out  RES_W  quotient/root, bit RES_W-1 has weight 2^0, MSB-first
- sticky_o  out  1  nonzero remainder (inexact)

## Operation
- Iteration count N = Pe+2, where Pe = P if prec_i==0, else min(prec_i,P). Cycle count C = ceil(N/ITER_UNITS).
- Divide: res_o[RES_W-1 -: N] = floor((A/B)·2^(N-1)). Lower bits are zero. sticky_o = (A·2^(N-1) mod B) != 0. The quotient lies in (0.5,2), so bit RES_W-1 may be 0. Downstream normalises.
- Sqrt: X = exp_odd_i ? 2A : A, X in [1,4). res_o[RES_W-1 -: N] = floor(sqrt(X)·2^(N-1)), so bit RES_W-1 is always 1. sticky_o = (root² != X exactly).
- Both operations use restoring radix-2 digit recurrence, one result bit per step, ITER_UNITS steps chained combinationally per cycle. In the final cycle only the remaining steps are applied, so no bits beyond N are produced. The partial remainder register is at least MANT_W+3 bits.
- FSM:
  - IDLE: in_ready_o=1. On in_valid_i && !kill_i, latch operands, op, fmt and N. Clear the step counter and go to ITER.
  - ITER: each cycle advance min(ITER_UNITS, remaining) steps. When remaining reaches 0 after this edge, go to DONE.
  - DONE: out_valid_o=1. res_o and sticky_o are stable. On out_ready_i, go to IDLE.
- kill_i wins over every other event. In any state it forces IDLE on the next edge, drops out_valid_o and discards the result. A request presented with kill_i high is not accepted.
- No accept in DONE. Throughput is one operation per C+2 cycles at minimum.
- Inputs are sampled only on the accept edge. Later changes have no effect.

## Timing
- Reset (rst_n low at an edge): state IDLE, in_ready_o=1 after release, out_valid_o=0, res_o=0, sticky_o=0, step counter 0. Reset mid-operation discards everything with no partial output.
- Accept edge k. ITER occupies edges k+1..k+C. out_valid_o is high from edge k+C.
- Latency from accept to out_valid_o is C cycles. Examples: FP32 with ITER_UNITS=2 gives N=26, C=13. FP64 with ITER_UNITS=4 gives N=55, C=14. FP16alt with ITER_UNITS=1 gives N=10, C=10.
- out_valid_o, res_o and sticky_o hold unchanged under out_ready_i=0 indefinitely.
- in_ready_o rises the edge after the out handshake.
- res_o keeps its last value in IDLE. It is undefined to consumers except when out_valid_o=1.

## Test plan
- FP32 divide, ITER_UNITS=2, A=53'h18_0000_0000_0000 (1.5), B=53'h10_0000_0000_0000 (1.0) -> after 13 cycles res_o=55'h60_0000_0000_0000, sticky_o=0.
- FP32 divide, A=1.0, B=1.5 -> res_o bits 54..29 = 0101…01 (alternating, starting 0), bits 28:0 = 0, sticky_o=1, latency 13.
- FP16 sqrt, A=1.0, exp_odd_i=1 -> N=13, res_o[54:42]=13'b1011010100000, lower bits 0, sticky_o=1. With exp_odd_i=0 -> res_o=55'h40_0000_0000_0000, sticky_o=0.
- FP64 divide, prec_i=8, ITER_UNITS=3 -> N=10, out_valid_o rises exactly 4 cycles after accept, res_o[44:0]=0.
- Backpressure: hold out_ready_i=0 for 20 cycles in DONE -> outputs stable, in_ready_o=0. Raising out_ready_i gives in_ready_o=1 on the next edge.
- kill_i asserted in ITER cycle 5, and separately together with in_valid_i in IDLE -> IDLE next edge, out_valid_o never rises, no accept. A following normal op (1.5/1.0) gives the correct result. Repeat the abort with rst_n low mid-ITER, expecting the same outcome.
